// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: FSM state encoding and step-count width shared by step_ctrl and its bench.
package step_ctrl_pkg;
   typedef enum logic [1:0] {S_STEP, S_FIRE, S_RUN} state_t;
   localparam int STEP_CNT_W = 16;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stability counter for one raw level input.
// Ports: i_clk clock; i_rst sync active-low reset; i_raw asynchronous input; o_level debounced stable level.
// ARM=1 refuses a rising toggle until the synchronised input has been seen low after reset settles,
// so an input already high at reset deassertion never looks like a fresh press.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter bit ARM = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0] r_sync, r_settle;
   logic r_level, r_armed, w_may_toggle;
   logic [CW-1:0] r_cnt;
   assign w_may_toggle = r_level | r_armed | ~ARM;
   assign o_level = r_level;
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_sync <= '0;
         r_settle <= '0;
         r_level <= 1'b0;
         r_armed <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         // r_sync[1] only reflects the real input once both synchroniser flops have refilled
         r_settle <= {r_settle[0], 1'b1};
         r_armed <= r_armed | (r_settle[1] & ~r_sync[1]);
         if (r_sync[1] == r_level) r_cnt <= '0;
         else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
            r_cnt <= '0;
            r_level <= w_may_toggle ? ~r_level : r_level;
         end else r_cnt <= r_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: single-step / free-run clock-enable generator for a CPU core.
// Ports: i_clk clock; i_rst sync active-low reset; i_btn_step raw step button; i_sw_run raw mode switch;
// i_hold freeze request; o_cpu_en one-cycle enable pulse; o_run_mode debounced mode; o_step_count pulses issued.
// Macro STEP_CTRL_COUNT_EN: when defined, o_step_count counts cpu_en pulses; otherwise it is tied to zero.
module step_ctrl import step_ctrl_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int RUN_DIV = 50000000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_btn_step,
   input  logic                  i_sw_run,
   input  logic                  i_hold,
   output logic                  o_cpu_en,
   output logic                  o_run_mode,
   output logic [STEP_CNT_W-1:0] o_step_count
);
   localparam int DIV_W = $clog2(RUN_DIV);
   state_t r_state, w_next;
   logic w_btn, r_btn_d, w_edge, w_div_last, w_cpu_en;
   logic [DIV_W-1:0] r_div;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ARM(1'b1)) u_btn (
      .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_btn_step), .o_level(w_btn)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ARM(1'b0)) u_run (
      .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_sw_run), .o_level(o_run_mode)
   );
   assign w_edge = w_btn & ~r_btn_d;
   assign w_div_last = r_div == DIV_W'(RUN_DIV - 1);
   assign o_cpu_en = w_cpu_en;
   always_comb begin
      w_next = r_state;
      w_cpu_en = 1'b0;
      case (r_state)
         S_STEP: w_next = o_run_mode ? S_RUN : (w_edge && !i_hold) ? S_FIRE : S_STEP;
         S_FIRE: begin
            w_next = o_run_mode ? S_RUN : S_STEP;
            w_cpu_en = !i_hold;
         end
         S_RUN: begin
            // the cycle that sees run_mode drop is the exit cycle and must stay quiet
            w_next = o_run_mode ? S_RUN : S_STEP;
            w_cpu_en = o_run_mode && !i_hold && w_div_last;
         end
         default: w_next = S_STEP;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_STEP;
         r_btn_d <= 1'b0;
         r_div <= '0;
      end else begin
         r_state <= w_next;
         r_btn_d <= w_btn;
         // held at zero outside S_RUN, so every entry starts a full period
         if (r_state != S_RUN) r_div <= '0;
         else if (!i_hold) r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
      end
   end
`ifdef STEP_CTRL_COUNT_EN
   logic [STEP_CNT_W-1:0] r_step_count;
   always_ff @(posedge i_clk) begin
      if (!i_rst) r_step_count <= '0;
      else if (w_cpu_en) r_step_count <= r_step_count + STEP_CNT_W'(1);
   end
   assign o_step_count = r_step_count;
`else
   assign o_step_count = '0;
`endif
endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed self-checking bench for step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=3.
module tb_step_ctrl;
   localparam int D = 4;
   localparam int R = 3;
`ifdef STEP_CTRL_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, btn = 1'b0, sw = 1'b0, hold = 1'b0;
   logic cpu_en, run_mode;
   logic [15:0] step_count;
   int checks = 0, errors = 0;
   int p, f, tot;
   always #5 clk = ~clk;
   step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(R)) dut (
      .i_clk(clk), .i_rst(rst), .i_btn_step(btn), .i_sw_run(sw), .i_hold(hold),
      .o_cpu_en(cpu_en), .o_run_mode(run_mode), .o_step_count(step_count)
   );
   function automatic logic [31:0] ec(input int v);
      return CNT_EN ? 32'(v & 16'hFFFF) : 32'h0;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // n cycles; pulse count and 0-based index of the first pulse (-1 if none)
   task automatic run(input int n, output int pulses, output int first);
      pulses = 0;
      first = -1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (cpu_en === 1'b1) begin
            if (pulses == 0) first = i;
            pulses++;
         end
      end
   endtask
   task automatic do_reset();
      rst = 1'b0; btn = 1'b0; sw = 1'b0; hold = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick(); tick(); tick();
   endtask
   initial begin
      tick(); tick();
      chk("rst_cpu_en", 32'(cpu_en), 0);
      chk("rst_run_mode", 32'(run_mode), 0);
      chk("rst_step_count", 32'(step_count), 0);
      rst = 1'b1;
      tick(); tick(); tick();
      btn = 1'b1;
      run(20, p, f);
      chk("step_pulses", p, 1);
      chk("step_latency", f, 7);
      btn = 1'b0;
      run(12, p, f);
      chk("release_pulses", p, 0);
      chk("step_count_1", 32'(step_count), ec(1));
      do_reset();
      tot = 0;
      for (int i = 0; i < 10; i++) begin
         btn = ~btn;
         run(2, p, f);
         tot += p;
      end
      btn = 1'b0;
      run(12, p, f);
      tot += p;
      chk("bounce_pulses", tot, 0);
      chk("bounce_count", 32'(step_count), ec(0));
      sw = 1'b1;
      run(6, p, f);
      chk("pre_run_mode", 32'(run_mode), 0);
      chk("pre_run_pulses", p, 0);
      run(31, p, f);
      chk("run_mode_on", 32'(run_mode), 1);
      chk("run_pulses", p, 10);
      chk("run_first", f, 3);
      tick();
      chk("run_count_10", 32'(step_count), ec(10));
      tick();
      hold = 1'b1;
      run(5, p, f);
      chk("hold_pulses", p, 0);
      hold = 1'b0;
      tick();
      chk("hold_resume", 32'(cpu_en), 1);
      tick();
      chk("hold_after", 32'(cpu_en), 0);
      chk("run_count_11", 32'(step_count), ec(11));
      tick(); tick();
      chk("run_pulse_pre", 32'(cpu_en), 1);
      hold = 1'b1;
      #1;
      chk("hold_gate", 32'(cpu_en), 0);
      hold = 1'b0;
      #1;
      chk("hold_ungate", 32'(cpu_en), 1);
      tick();
      chk("run_count_12", 32'(step_count), ec(12));
      sw = 1'b0;
      run(10, p, f);
      chk("run_exit_mode", 32'(run_mode), 0);
      chk("run_exit_pulses", p, 2);
      chk("run_count_14", 32'(step_count), ec(14));
`ifdef STEP_CTRL_COUNT_EN
      force dut.r_step_count = 16'hFFFF;
      tick();
      release dut.r_step_count;
      chk("preload", 32'(step_count), 32'hFFFF);
`endif
      btn = 1'b1;
      run(20, p, f);
      chk("wrap_pulses", p, 1);
      btn = 1'b0;
      run(12, p, f);
      chk("wrap_count", 32'(step_count), 0);
      hold = 1'b1;
      btn = 1'b1;
      run(12, p, f);
      chk("held_edge", p, 0);
      hold = 1'b0;
      run(10, p, f);
      chk("dropped_edge", p, 0);
      btn = 1'b0;
      run(12, p, f);
      do_reset();
      btn = 1'b1;
      run(7, p, f);
      chk("fire_pre", p, 0);
      tick();
      chk("fire_pulse", 32'(cpu_en), 1);
      rst = 1'b0;
      tick();
      chk("abort_cpu_en", 32'(cpu_en), 0);
      chk("abort_run_mode", 32'(run_mode), 0);
      chk("abort_count", 32'(step_count), 0);
      rst = 1'b1;
      run(30, p, f);
      chk("abort_no_pulse", p, 0);
      btn = 1'b0;
      run(12, p, f);
      btn = 1'b1;
      run(20, p, f);
      chk("fresh_pulses", p, 1);
      chk("fresh_latency", f, 7);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a button level change.
REQ-002 Parameter RUN_DIV, default 50000000: clk cycles per cpu_en pulse in run mode, at least 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-low.
REQ-005 btn_step  input  1  raw, asynchronous, bouncing single-step pushbutton.
REQ-006 sw_run  input  1  raw, asynchronous mode switch: 1 = free-run, 0 = single-step.
REQ-007 hold  input  1  synchronous freeze request, e.g. the board stall switch.
REQ-008 cpu_en  output  1  one-cycle clock-enable pulse consumed by the CPU core.
REQ-009 run_mode  output  1  debounced/synchronised sw_run currently in effect.
REQ-010 step_count  output  16  number of cpu_en pulses issued since reset.

Function
REQ-011 btn_step and sw_run SHALL each pass through a 2-flop synchroniser before any other use.
REQ-012 Debounce: a counter SHALL increment while the synchronised level differs from the stable level, clear on any cycle where they match, and toggle the stable level and clear when it reaches DEBOUNCE_CYCLES.
REQ-013 sw_run SHALL use the same debounce rule; run_mode is its stable level.
REQ-014 FSM states: S_STEP (wait), S_FIRE (pulse), S_RUN (free-run).
REQ-015 S_STEP -> S_FIRE on stable-button rising edge with hold=0; S_STEP -> S_RUN when run_mode=1.
REQ-016 S_FIRE SHALL last exactly one cycle with cpu_en=1, then go to S_STEP; if run_mode=1 it goes to S_RUN instead.
REQ-017 S_RUN -> S_STEP when run_mode=0; no pulse is issued in the transition cycle.
REQ-018 In S_RUN, divider counter counts 0..RUN_DIV-1 and wraps; cpu_en=1 exactly in the cycle the counter equals RUN_DIV-1.
REQ-019 Divider counter SHALL clear to 0 on every entry to S_RUN, so the first run pulse comes RUN_DIV cycles after entry.
REQ-020 hold=1 SHALL force cpu_en=0 and freeze the divider counter.
REQ-021 A step edge arriving while hold=1 is dropped, not queued.
REQ-022 Button edges in S_RUN are ignored; releasing the button never produces a pulse.
REQ-023 Step latency, raw button high to cpu_en: 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-024 step_count SHALL increment by 1 in the cycle after each cpu_en pulse and wrap 0xFFFF -> 0x0000.
REQ-025 cpu_en SHALL never be high in two consecutive cycles in step mode.

Reset
REQ-026 rst=0 at a clock edge SHALL set state S_STEP, all counters 0, stable levels 0, synchronisers 0, cpu_en=0, run_mode=0, step_count=0.
REQ-027 Reset asserted mid-pulse or mid-debounce SHALL abort it; no pulse follows deassertion until a fresh debounced edge or run period completes.

Configuration
REQ-028 With macro STEP_CTRL_COUNT_EN defined, step_count is implemented per REQ-024.
REQ-029 Without STEP_CTRL_COUNT_EN, step_count SHALL be tied to 16'h0000, with no counter flops.

Structure
REQ-030 Package step_ctrl_pkg SHALL hold the FSM state enum (S_STEP, S_FIRE, S_RUN) and the step-count width constant (16).
REQ-031 Sub-module btn_debounce (synchroniser plus REQ-012 counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice: once for btn_step, once for sw_run.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=3)
REQ-032 Reset, then btn_step held high 20 cycles -> exactly one cpu_en pulse, 7 cycles after the first high sample; step_count=1.
REQ-033 btn_step toggled every 2 cycles for 20 cycles, then low -> no cpu_en; step_count=0.
REQ-034 sw_run=1 held -> S_RUN entered; cpu_en high every 3rd cycle; 10 pulses -> step_count=10.
REQ-035 In run mode, hold=1 for 5 cycles in the middle of a period -> no pulses during hold; after release, next pulse lands at the frozen count plus the remaining cycles.
REQ-036 Preload step_count 0xFFFF (force), one step -> step_count=0x0000.
REQ-037 rst=0 during S_FIRE -> cpu_en=0 next cycle, all outputs 0, no pulse after release while btn_step stays high.
